// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg
//   Shared definitions for the exception/interrupt controller: cause code
//   values written to CP0 cause, the controller state encoding, the default
//   handler vector and the synchronous-exception priority encoder.
package exc_ctrl_pkg;

  // Cause codes as seen by software in the CP0 cause register
  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_INT  = 3'd1;
  localparam logic [2:0] CAUSE_SYS  = 3'd2;
  localparam logic [2:0] CAUSE_RI   = 3'd3;
  localparam logic [2:0] CAUSE_OV   = 3'd4;
  localparam logic [2:0] CAUSE_BRK  = 3'd5;

  // Default handler entry address
  localparam logic [31:0] VECTOR_DEFAULT = 32'h0000_0080;

  // Controller states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRAP    = 3'd1,
    ST_HANDLER = 3'd2,
    ST_RETURN  = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  // Fixed priority among synchronous exceptions: ov > ri > sys > brk.
  // Returns CAUSE_NONE when no synchronous exception is flagged.
  function automatic logic [2:0] sync_cause(input logic ov,
                                            input logic ri,
                                            input logic sys,
                                            input logic brk);
    logic [2:0] code;
    code = CAUSE_NONE;
    if (ov)       code = CAUSE_OV;
    else if (ri)  code = CAUSE_RI;
    else if (sys) code = CAUSE_SYS;
    else if (brk) code = CAUSE_BRK;
    return code;
  endfunction

endpackage

// File: rtl/exc_ctrl_irq_latch.sv
// exc_ctrl_irq_latch
//   Brings the asynchronous level interrupt into the clock domain with a
//   two-flop synchroniser, detects its rising edge and holds a pending flag
//   until the controller services it.
// Ports:
//   clk      in   core clock
//   rst      in   asynchronous active-high reset
//   irq      in   external interrupt level (asynchronous)
//   clr      in   controller is servicing the pending interrupt this cycle
//   pending  out  an interrupt edge has been seen and not yet serviced
module exc_ctrl_irq_latch (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  output logic pending
);

  logic sync1;
  logic sync2;
  logic prev;
  logic rise;

  // Edge is seen on the synchronised level against its one-cycle-old copy
  assign rise = sync2 & ~prev;

  // Synchroniser, edge-detect history and pending flag. A new edge wins
  // over a clear in the same cycle so that no interrupt is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync1   <= irq;
      sync2   <= sync1;
      prev    <= sync2;
      pending <= rise | (pending & ~clr);
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl
//   Exception/interrupt controller for the MIPS core. Samples exception flags
//   at instruction commit, prioritises them, runs the trap and return
//   sequences and drives the CP0 cause/EPC write strobes and PC redirect.
//   Every output is a register, so there is no input-to-output combinational
//   path.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   commit                         an instruction completes this cycle
//   pc, pc_next                    committing pc and the pc that would follow
//   exc_ov/exc_ri/exc_sys/exc_brk  synchronous exception flags with commit
//   eret                           committing instruction is ERET
//   irq                            external interrupt level (asynchronous)
//   ie_we, ie_in                   software write of interrupt enable
//   cause_we, cause_code           CP0 cause write strobe and value
//   epc_we, epc                    CP0 EPC write strobe and held return address
//   pc_redirect, redirect_pc       force the PC to redirect_pc on next edge
//   exl, ie, halted, int_pending   status
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] VECTOR   = VECTOR_DEFAULT,
  parameter logic        RESET_IE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic        exc_ov,
  input  logic        exc_ri,
  input  logic        exc_sys,
  input  logic        exc_brk,
  input  logic        eret,
  input  logic        irq,
  input  logic        ie_we,
  input  logic        ie_in,
  output logic        cause_we,
  output logic [2:0]  cause_code,
  output logic        epc_we,
  output logic [31:0] epc,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        exl,
  output logic        ie,
  output logic        halted,
  output logic        int_pending
);

  state_t     state;
  logic [2:0] idle_code;
  logic [2:0] handler_code;
  logic [2:0] idle_sync;
  logic       int_clr;

  // The pending interrupt is retired during the TRAP cycle that services it;
  // a trap taken for a synchronous cause leaves it pending.
  assign int_clr = (state == ST_TRAP) && (cause_code == CAUSE_INT);

  exc_ctrl_irq_latch u_irq_latch (
    .clk     (clk),
    .rst     (rst),
    .irq     (irq),
    .clr     (int_clr),
    .pending (int_pending)
  );

  // Cause selection. Outside the handler an ERET is illegal and is reported
  // as a reserved instruction; interrupts only compete when enabled and
  // always lose to a synchronous exception on the same commit. Inside the
  // handler interrupts are masked, so only synchronous causes are decoded.
  always_comb begin
    idle_sync    = sync_cause(exc_ov, exc_ri | eret, exc_sys, exc_brk);
    handler_code = sync_cause(exc_ov, exc_ri, exc_sys, exc_brk);
    idle_code    = CAUSE_NONE;
    if (idle_sync != CAUSE_NONE)
      idle_code = idle_sync;
    else if (int_pending && ie)
      idle_code = CAUSE_INT;
  end

  // Main controller FSM. Strobes are registered at the commit edge so they
  // are high for exactly the cycle after the committing instruction. TRAP
  // and RETURN last one cycle each and ignore commits. HALT is only left by
  // reset; entering it pulses cause_we once to record the nested cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cause_we    <= 1'b0;
      cause_code  <= CAUSE_NONE;
      epc_we      <= 1'b0;
      epc         <= 32'h0;
      pc_redirect <= 1'b0;
      redirect_pc <= 32'h0;
      exl         <= 1'b0;
      halted      <= 1'b0;
    end else begin
      cause_we    <= 1'b0;
      epc_we      <= 1'b0;
      pc_redirect <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (commit && (idle_code != CAUSE_NONE)) begin
            state       <= ST_TRAP;
            cause_code  <= idle_code;
            // Interrupts return to the instruction that was about to run;
            // synchronous exceptions return to the faulting instruction.
            epc         <= (idle_code == CAUSE_INT) ? pc_next : pc;
            cause_we    <= 1'b1;
            epc_we      <= 1'b1;
            pc_redirect <= 1'b1;
            redirect_pc <= VECTOR;
          end
        end
        ST_TRAP: begin
          state <= ST_HANDLER;
          exl   <= 1'b1;
        end
        ST_HANDLER: begin
          if (commit) begin
            // A fault inside the handler is fatal even if the same
            // instruction also carries ERET.
            if (handler_code != CAUSE_NONE) begin
              state      <= ST_HALT;
              halted     <= 1'b1;
              cause_code <= handler_code;
              cause_we   <= 1'b1;
            end else if (eret) begin
              state       <= ST_RETURN;
              pc_redirect <= 1'b1;
              redirect_pc <= epc;
            end
          end
        end
        ST_RETURN: begin
          state <= ST_IDLE;
          exl   <= 1'b0;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Interrupt enable is owned by software alone; it is frozen once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ie <= RESET_IE;
    else if (ie_we && (state != ST_HALT))
      ie <= ie_in;
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl
//   Directed testbench for exc_ctrl: drives instruction commits, exception
//   flags, interrupts and ERETs, and compares outputs with hand-computed
//   values one cycle after each clock edge.
module tb_exc_ctrl;

  logic        clk;
  logic        rst;
  logic        commit;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        exc_ov;
  logic        exc_ri;
  logic        exc_sys;
  logic        exc_brk;
  logic        eret;
  logic        irq;
  logic        ie_we;
  logic        ie_in;
  logic        cause_we;
  logic [2:0]  cause_code;
  logic        epc_we;
  logic [31:0] epc;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        exl;
  logic        ie;
  logic        halted;
  logic        int_pending;

  int checks;
  int failures;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_OV   = 4'b1000;
  localparam logic [3:0] F_SYS  = 4'b0010;

  exc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit),
    .pc          (pc),
    .pc_next     (pc_next),
    .exc_ov      (exc_ov),
    .exc_ri      (exc_ri),
    .exc_sys     (exc_sys),
    .exc_brk     (exc_brk),
    .eret        (eret),
    .irq         (irq),
    .ie_we       (ie_we),
    .ie_in       (ie_in),
    .cause_we    (cause_we),
    .cause_code  (cause_code),
    .epc_we      (epc_we),
    .epc         (epc),
    .pc_redirect (pc_redirect),
    .redirect_pc (redirect_pc),
    .exl         (exl),
    .ie          (ie),
    .halted      (halted),
    .int_pending (int_pending)
  );

  // 10 ns core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs (flags = {ov, ri, sys, brk}), waits for the
  // clock edge and returns 1 ns later with single-cycle inputs cleared
  task automatic applyStimulus(input logic c, input logic [31:0] p,
                               input logic [31:0] pn, input logic [3:0] flags,
                               input logic er, input logic iw, input logic iv);
    commit  = c;
    pc      = p;
    pc_next = pn;
    {exc_ov, exc_ri, exc_sys, exc_brk} = flags;
    eret    = er;
    ie_we   = iw;
    ie_in   = iv;
    @(posedge clk);
    #1;
    commit = 1'b0;
    {exc_ov, exc_ri, exc_sys, exc_brk} = 4'b0000;
    eret   = 1'b0;
    ie_we  = 1'b0;
    ie_in  = 1'b0;
  endtask

  // Idle cycle with no commit
  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, F_NONE, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    commit   = 1'b0;
    pc       = 32'h0;
    pc_next  = 32'h0;
    {exc_ov, exc_ri, exc_sys, exc_brk} = 4'b0000;
    eret     = 1'b0;
    irq      = 1'b0;
    ie_we    = 1'b0;
    ie_in    = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cause_we", 32'(cause_we), 32'd0);
    checkOutput("rst_cause_code", 32'(cause_code), 32'd0);
    checkOutput("rst_epc_we", 32'(epc_we), 32'd0);
    checkOutput("rst_epc", epc, 32'h0);
    checkOutput("rst_pc_redirect", 32'(pc_redirect), 32'd0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
    checkOutput("rst_exl", 32'(exl), 32'd0);
    checkOutput("rst_ie", 32'(ie), 32'd1);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_int_pending", 32'(int_pending), 32'd0);
    rst = 1'b0;

    // Plain commit: nothing happens
    applyStimulus(1'b1, 32'h4, 32'h8, F_NONE, 1'b0, 1'b0, 1'b0);
    checkOutput("plain_cause_we", 32'(cause_we), 32'd0);
    checkOutput("plain_redirect", 32'(pc_redirect), 32'd0);

    // Overflow at 0x10: strobes in the following cycle
    applyStimulus(1'b1, 32'h10, 32'h14, F_OV, 1'b0, 1'b0, 1'b0);
    checkOutput("ov_cause_we", 32'(cause_we), 32'd1);
    checkOutput("ov_epc_we", 32'(epc_we), 32'd1);
    checkOutput("ov_cause_code", 32'(cause_code), 32'd4);
    checkOutput("ov_epc", epc, 32'h10);
    checkOutput("ov_redirect", 32'(pc_redirect), 32'd1);
    checkOutput("ov_redirect_pc", redirect_pc, 32'h80);
    checkOutput("ov_exl_trap", 32'(exl), 32'd0);

    // Commit during TRAP is ignored; strobes last one cycle, exl rises
    applyStimulus(1'b1, 32'h14, 32'h18, F_SYS, 1'b0, 1'b0, 1'b0);
    checkOutput("hnd_cause_we", 32'(cause_we), 32'd0);
    checkOutput("hnd_epc_we", 32'(epc_we), 32'd0);
    checkOutput("hnd_redirect", 32'(pc_redirect), 32'd0);
    checkOutput("hnd_exl", 32'(exl), 32'd1);
    checkOutput("hnd_cause_code", 32'(cause_code), 32'd4);
    checkOutput("hnd_halted", 32'(halted), 32'd0);

    // ERET returns to the faulting pc
    applyStimulus(1'b1, 32'h80, 32'h84, F_NONE, 1'b1, 1'b0, 1'b0);
    checkOutput("ret_redirect", 32'(pc_redirect), 32'd1);
    checkOutput("ret_redirect_pc", redirect_pc, 32'h10);
    checkOutput("ret_cause_we", 32'(cause_we), 32'd0);

    // Commit during RETURN is ignored
    applyStimulus(1'b1, 32'h10, 32'h14, F_OV, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_redirect", 32'(pc_redirect), 32'd0);
    checkOutput("idle_exl", 32'(exl), 32'd0);
    checkOutput("idle_cause_we", 32'(cause_we), 32'd0);

    // irq reaches int_pending on the third edge
    irq = 1'b1;
    idleCycle();
    idleCycle();
    checkOutput("irq_2edges", 32'(int_pending), 32'd0);
    idleCycle();
    checkOutput("irq_3edges", 32'(int_pending), 32'd1);
    checkOutput("irq_no_commit", 32'(cause_we), 32'd0);
    irq = 1'b0;

    // ov + sys + pending irq on one commit: overflow wins
    applyStimulus(1'b1, 32'h20, 32'h24, F_OV | F_SYS, 1'b0, 1'b0, 1'b0);
    checkOutput("mix_cause_code", 32'(cause_code), 32'd4);
    checkOutput("mix_epc", epc, 32'h20);
    checkOutput("mix_cause_we", 32'(cause_we), 32'd1);
    checkOutput("mix_pending", 32'(int_pending), 32'd1);
    idleCycle();
    checkOutput("mix_pending_hnd", 32'(int_pending), 32'd1);
    applyStimulus(1'b1, 32'h84, 32'h88, F_NONE, 1'b1, 1'b0, 1'b0);
    checkOutput("mix_ret_pc", redirect_pc, 32'h20);
    idleCycle();
    checkOutput("mix_idle_cause_we", 32'(cause_we), 32'd0);

    // Pending interrupt taken at first commit after return
    applyStimulus(1'b1, 32'h20, 32'h24, F_NONE, 1'b0, 1'b0, 1'b0);
    checkOutput("int_cause_code", 32'(cause_code), 32'd1);
    checkOutput("int_epc", epc, 32'h24);
    checkOutput("int_epc_we", 32'(epc_we), 32'd1);
    checkOutput("int_redirect_pc", redirect_pc, 32'h80);
    checkOutput("int_pending_trap", 32'(int_pending), 32'd1);
    idleCycle();
    checkOutput("int_pending_clr", 32'(int_pending), 32'd0);
    applyStimulus(1'b1, 32'h88, 32'h8c, F_NONE, 1'b1, 1'b0, 1'b0);
    checkOutput("int_ret_pc", redirect_pc, 32'h24);
    idleCycle();

    // Interrupt masked by ie=0 stays pending until enabled
    applyStimulus(1'b0, 32'h0, 32'h0, F_NONE, 1'b0, 1'b1, 1'b0);
    checkOutput("ie_clear", 32'(ie), 32'd0);
    irq = 1'b1;
    idleCycle();
    idleCycle();
    irq = 1'b0;
    idleCycle();
    checkOutput("masked_pending", 32'(int_pending), 32'd1);
    applyStimulus(1'b1, 32'h50, 32'h54, F_NONE, 1'b0, 1'b0, 1'b0);
    checkOutput("masked_no_trap", 32'(cause_we), 32'd0);
    checkOutput("masked_still_pend", 32'(int_pending), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, F_NONE, 1'b0, 1'b1, 1'b1);
    checkOutput("ie_set", 32'(ie), 32'd1);
    applyStimulus(1'b1, 32'h60, 32'h64, F_NONE, 1'b0, 1'b0, 1'b0);
    checkOutput("unmask_cause_code", 32'(cause_code), 32'd1);
    checkOutput("unmask_epc", epc, 32'h64);
    checkOutput("unmask_cause_we", 32'(cause_we), 32'd1);
    idleCycle();
    checkOutput("unmask_pend_clr", 32'(int_pending), 32'd0);
    checkOutput("unmask_exl", 32'(exl), 32'd1);

    // Syscall inside the handler halts the core
    applyStimulus(1'b1, 32'h70, 32'h74, F_SYS, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_halted", 32'(halted), 32'd1);
    checkOutput("halt_cause_code", 32'(cause_code), 32'd2);
    checkOutput("halt_cause_we", 32'(cause_we), 32'd1);
    checkOutput("halt_epc_we", 32'(epc_we), 32'd0);
    checkOutput("halt_redirect", 32'(pc_redirect), 32'd0);
    checkOutput("halt_epc", epc, 32'h64);
    applyStimulus(1'b1, 32'h74, 32'h78, F_OV, 1'b0, 1'b1, 1'b0);
    checkOutput("halt_cause_we_once", 32'(cause_we), 32'd0);
    checkOutput("halt_code_held", 32'(cause_code), 32'd2);
    checkOutput("halt_sticky", 32'(halted), 32'd1);
    checkOutput("halt_ie_frozen", 32'(ie), 32'd1);

    // Reset leaves HALT
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("halt_rst", 32'(halted), 32'd0);
    rst = 1'b0;

    // ERET in IDLE is a reserved instruction
    applyStimulus(1'b1, 32'h90, 32'h94, F_NONE, 1'b1, 1'b0, 1'b0);
    checkOutput("eret_idle_code", 32'(cause_code), 32'd3);
    checkOutput("eret_idle_epc", epc, 32'h90);
    checkOutput("eret_idle_cause_we", 32'(cause_we), 32'd1);

    // Reset during TRAP drops strobes immediately
    rst = 1'b1;
    #1;
    checkOutput("abort_cause_we", 32'(cause_we), 32'd0);
    checkOutput("abort_epc_we", 32'(epc_we), 32'd0);
    checkOutput("abort_redirect", 32'(pc_redirect), 32'd0);
    checkOutput("abort_cause_code", 32'(cause_code), 32'd0);
    rst = 1'b0;
    idleCycle();
    checkOutput("abort_exl", 32'(exl), 32'd0);
    applyStimulus(1'b1, 32'h4, 32'h8, F_NONE, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_idle_cause_we", 32'(cause_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
